// File: rtl/rv32i_alu_pkg.sv
// rv32i_alu_pkg: shared widths and ALU operation encodings for the execution slice
package rv32i_alu_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [3:0] {
    ALU_INVALID = 4'b0000,
    ALU_AND     = 4'b0001,
    ALU_OR      = 4'b0010,
    ALU_XOR     = 4'b0011,
    ALU_SLL     = 4'b0101,
    ALU_SRL     = 4'b0110,
    ALU_SRA     = 4'b0111,
    ALU_ADD     = 4'b1000,
    ALU_SUB     = 4'b1100,
    ALU_SLT     = 4'b1101,
    ALU_SLTU    = 4'b1111
  } alu_control_t;
endpackage

// File: rtl/dff_en.sv
// dff_en: enabled register with synchronous active-high reset to a parameterised value
module dff_en #(
  parameter int N = 32,
  parameter logic [N-1:0] RESET = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= RESET;
    else if (ena) q <= d;
endmodule

// File: rtl/rv32i_regfile_alu_slice.sv
// rv32i_regfile_alu_slice: RV32I register file, A/B/ALU hold registers and combinational ALU
module rv32i_regfile_alu_slice
  import rv32i_alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_ena,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr0,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  output logic [XLEN-1:0]       rd_data0,
  output logic [XLEN-1:0]       rd_data1,
  input  logic                  ab_ena,
  output logic [XLEN-1:0]       reg_a,
  output logic [XLEN-1:0]       reg_b,
  input  logic [XLEN-1:0]       a,
  input  logic [XLEN-1:0]       b,
  input  logic [3:0]            alu_control,
  output logic [XLEN-1:0]       alu_result,
  output logic                  overflow,
  output logic                  zero,
  output logic                  equal,
  input  logic                  alu_last_ena,
  output logic [XLEN-1:0]       alu_last
);
  logic [XLEN-1:0] regs [1:31];
  logic [XLEN-1:0] sum, diff;
  // x0 has no storage; reads of it are forced to zero and writes are dropped
  always_ff @(posedge clk)
    if (rst) for (int i = 1; i < 32; i++) regs[i] <= '0;
    else if (wr_ena && wr_addr != '0) regs[wr_addr] <= wr_data;
  assign rd_data0 = (rd_addr0 == '0) ? '0 : regs[rd_addr0];
  assign rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
  assign sum  = a + b;
  assign diff = a - b;
  always_comb begin
    alu_result = '0;
    overflow = 1'b0;
    case (alu_control)
      ALU_AND:  alu_result = a & b;
      ALU_OR:   alu_result = a | b;
      ALU_XOR:  alu_result = a ^ b;
      ALU_SLL:  alu_result = a << b[4:0];
      ALU_SRL:  alu_result = a >> b[4:0];
      ALU_SRA:  alu_result = $signed(a) >>> b[4:0];
      ALU_ADD: begin
        alu_result = sum;
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        alu_result = diff;
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_SLT:  alu_result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: alu_result = {31'b0, a < b};
      default:  alu_result = '0;
    endcase
  end
  assign zero  = (alu_result == '0);
  assign equal = (a == b);
  dff_en #(.N(XLEN)) u_reg_a (.clk(clk), .rst(rst), .ena(ab_ena), .d(rd_data0), .q(reg_a));
  dff_en #(.N(XLEN)) u_reg_b (.clk(clk), .rst(rst), .ena(ab_ena), .d(rd_data1), .q(reg_b));
  dff_en #(.N(XLEN)) u_alu_last (.clk(clk), .rst(rst), .ena(alu_last_ena), .d(alu_result), .q(alu_last));
endmodule

// File: tb/tb_rv32i_regfile_alu_slice.sv
// tb_rv32i_regfile_alu_slice: random + directed checks against a behavioural model
module tb_rv32i_regfile_alu_slice;
  logic        clk = 1'b0;
  logic        rst, wr_ena, ab_ena, alu_last_ena;
  logic [4:0]  wr_addr, rd_addr0, rd_addr1;
  logic [31:0] wr_data, a, b;
  logic [3:0]  alu_control;
  logic [31:0] rd_data0, rd_data1, reg_a, reg_b, alu_result, alu_last;
  logic        overflow, zero, equal;
  int tests = 0;
  int fails = 0;
  bit armed = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_a = '0, m_b = '0, m_last = '0;

  rv32i_regfile_alu_slice dut (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(rd_data0), .rd_data1(rd_data1),
    .ab_ena(ab_ena), .reg_a(reg_a), .reg_b(reg_b), .a(a), .b(b),
    .alu_control(alu_control), .alu_result(alu_result), .overflow(overflow),
    .zero(zero), .equal(equal), .alu_last_ena(alu_last_ena), .alu_last(alu_last)
  );

  always #5 clk = ~clk;

  // returns {overflow, result}; overflow judged by whether the exact sum/difference fits in 32 signed bits
  function automatic logic [32:0] alu_ref(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    longint sa = $signed(x);
    longint sb = $signed(y);
    longint s;
    logic [31:0] r = '0;
    logic ov = 1'b0;
    case (op)
      4'b0001: r = x & y;
      4'b0010: r = x | y;
      4'b0011: r = x ^ y;
      4'b0101: r = x << y[4:0];
      4'b0110: r = x >> y[4:0];
      4'b0111: begin s = sa >>> y[4:0]; r = s[31:0]; end
      4'b1000: begin s = sa + sb; r = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
      4'b1100: begin s = sa - sb; r = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
      4'b1101: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1111: r = (x < y) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {ov, r};
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] ad);
    return (ad == 0) ? 32'd0 : m_regs[ad];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial for (int i = 0; i < 32; i++) m_regs[i] = '0;

  always @(posedge clk) begin
    logic [32:0] ar;
    ar = alu_ref(a, b, alu_control);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_a = '0; m_b = '0; m_last = '0;
    end else begin
      if (ab_ena) begin m_a = m_rd(rd_addr0); m_b = m_rd(rd_addr1); end
      if (alu_last_ena) m_last = ar[31:0];
      if (wr_ena && wr_addr != 0) m_regs[wr_addr] = wr_data;
    end
  end

  always @(negedge clk) if (armed) begin
    logic [32:0] ar;
    ar = alu_ref(a, b, alu_control);
    chk("rd_data0", rd_data0, m_rd(rd_addr0));
    chk("rd_data1", rd_data1, m_rd(rd_addr1));
    chk("reg_a", reg_a, m_a);
    chk("reg_b", reg_b, m_b);
    chk("alu_last", alu_last, m_last);
    chk("alu_result", alu_result, ar[31:0]);
    chk("overflow", {31'b0, overflow}, {31'b0, ar[32]});
    chk("zero", {31'b0, zero}, {31'b0, ar[31:0] == 0});
    chk("equal", {31'b0, equal}, {31'b0, a == b});
  end

  task automatic alu_lit(input string name, input logic [31:0] x, input logic [31:0] y, input logic [3:0] op,
                         input logic [31:0] r, input logic ov, input logic z);
    logic [32:0] ar;
    a = x; b = y; alu_control = op;
    #1;
    ar = alu_ref(x, y, op);
    chk({name, "_res"}, alu_result, r);
    chk({name, "_ov"}, {31'b0, overflow}, {31'b0, ov});
    chk({name, "_zero"}, {31'b0, zero}, {31'b0, z});
    chk({name, "_model"}, ar[31:0], r);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; wr_ena = 1; wr_addr = 5; wr_data = 32'hFFFF_FFFF;
    rd_addr0 = 0; rd_addr1 = 0; ab_ena = 1; alu_last_ena = 1;
    a = 32'h1; b = 32'h2; alu_control = 4'b1000;
    tick(); tick();
    armed = 1;
    rst = 0; wr_ena = 0; ab_ena = 0; alu_last_ena = 0;
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = 5'(i);
      #1;
      chk("rst_read", rd_data0, 32'd0);
    end
    chk("rst_reg_a", reg_a, 32'd0);
    chk("rst_reg_b", reg_b, 32'd0);
    chk("rst_alu_last", alu_last, 32'd0);
    wr_ena = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF; rd_addr0 = 5;
    #1;
    chk("same_cycle_old", rd_data0, 32'd0);
    tick();
    chk("x5_write", rd_data0, 32'hDEAD_BEEF);
    wr_addr = 0; wr_data = 32'h1234_5678; rd_addr1 = 0;
    tick();
    chk("x0_discard", rd_data1, 32'd0);
    chk("x5_keep", rd_data0, 32'hDEAD_BEEF);
    wr_ena = 0;
    alu_lit("add_ovf", 32'h7FFF_FFFF, 32'h1, 4'b1000, 32'h8000_0000, 1, 0);
    alu_lit("sub_zero", 32'd5, 32'd5, 4'b1100, 32'd0, 0, 1);
    chk("sub_equal", {31'b0, equal}, 32'd1);
    alu_lit("sub_ovf", 32'h8000_0000, 32'h1, 4'b1100, 32'h7FFF_FFFF, 1, 0);
    alu_lit("sra", 32'hF000_0000, 32'h24, 4'b0111, 32'hFF00_0000, 0, 0);
    alu_lit("srl", 32'hF000_0000, 32'h24, 4'b0110, 32'h0F00_0000, 0, 0);
    alu_lit("sll", 32'h1, 32'h24, 4'b0101, 32'h10, 0, 0);
    alu_lit("slt", 32'hFFFF_FFFF, 32'h1, 4'b1101, 32'h1, 0, 0);
    alu_lit("sltu", 32'hFFFF_FFFF, 32'h1, 4'b1111, 32'h0, 0, 1);
    alu_lit("invalid", 32'hFFFF_FFFF, 32'h1, 4'b0000, 32'h0, 0, 1);
    alu_lit("unlisted", 32'hFFFF_FFFF, 32'h1, 4'b1010, 32'h0, 0, 1);
    wr_ena = 1; wr_addr = 1; wr_data = 7;
    tick();
    wr_addr = 2; wr_data = 9;
    tick();
    wr_ena = 0; rd_addr0 = 1; rd_addr1 = 2; ab_ena = 1;
    tick();
    ab_ena = 0;
    chk("hold_a", reg_a, 32'd7);
    chk("hold_b", reg_b, 32'd9);
    wr_ena = 1; wr_addr = 1; wr_data = 100;
    tick();
    wr_ena = 0;
    chk("hold_a_keep", reg_a, 32'd7);
    a = 3; b = 4; alu_control = 4'b1000; alu_last_ena = 1;
    tick();
    alu_last_ena = 0; a = 10;
    chk("alu_last_cap", alu_last, 32'd7);
    tick();
    chk("alu_last_keep", alu_last, 32'd7);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      wr_ena = $urandom_range(0, 1);
      wr_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wr_data = pick();
      rd_addr0 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rd_addr1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ab_ena = $urandom_range(0, 1);
      alu_last_ena = $urandom_range(0, 1);
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? a : pick();
      alu_control = 4'($urandom);
      tick();
    end
    rst = 0;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
